// File: rtl/gfx_pkg.sv
// Shared types and constants for the VRAM bus scheduler.
package gfx_pkg;

  localparam int VADDR_W = 16;
  localparam int VDATA_W = 8;
  localparam int WR_ENTRY_W = VADDR_W + VDATA_W;

  // Slot operation; doubles as the scheduler FSM state.
  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_FILL  = 2'd3
  } op_t;

  typedef struct packed {
    op_t                op;
    logic [VADDR_W-1:0] addr;
    logic [VDATA_W-1:0] data;
  } slot_t;

  localparam slot_t SLOT_IDLE = '{op: OP_NONE, addr: 16'h0000, data: 8'h00};

  // True for operations that put data on the VRAM bus.
  function automatic logic op_writes(op_t op);
    return (op == OP_WRITE) || (op == OP_FILL);
  endfunction

endpackage

// File: rtl/gfx_vram_dma_if.sv
// CPU-side request/response bundle of the VRAM scheduler.
interface gfx_vram_dma_if;
  import gfx_pkg::*;

  logic               i_wr_req;
  logic [VADDR_W-1:0] i_wr_addr;
  logic [VDATA_W-1:0] i_wr_data;
  logic               o_wr_full;
  logic               i_rd_req;
  logic [VADDR_W-1:0] i_rd_addr;
  logic [VDATA_W-1:0] o_rd_data;
  logic               o_rd_valid;
  logic               i_fill_start;
  logic [VADDR_W-1:0] i_fill_addr;
  logic [15:0]        i_fill_len;
  logic [VDATA_W-1:0] i_fill_value;
  logic               o_fill_busy;

  // CPU bus glue side: issues requests, observes status.
  modport master (
    output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
           i_fill_start, i_fill_addr, i_fill_len, i_fill_value,
    input  o_wr_full, o_rd_data, o_rd_valid, o_fill_busy
  );

  // Scheduler side.
  modport slave (
    input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
           i_fill_start, i_fill_addr, i_fill_len, i_fill_value,
    output o_wr_full, o_rd_data, o_rd_valid, o_fill_busy
  );

endinterface

// File: rtl/gfx_wr_fifo.sv
// Write queue: synchronous FIFO with registered full/empty flags.
// A push while full is dropped even if a pop happens in the same cycle.
module gfx_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push_i && !full_q;
  assign pop_ok_s  = pop_i && !empty_q;

  // Occupancy next-state from the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == {(AW+1){1'b0}});
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/gfx_vram_dma.sv
// VRAM bus scheduler: one-slot access FSM arbitrating a single pending
// read, a CPU write queue and a block-fill engine onto the VRAM pins in
// cycles where the scanout engine leaves the bus free.
module gfx_vram_dma
  import gfx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  gfx_vram_dma_if.slave      cpu,
  input  logic               i_free_vbus_b,
  output logic [VADDR_W-1:0] o_vaddr,
  output logic [VDATA_W-1:0] o_vdata,
  output logic               o_vdata_oe,
  input  logic [VDATA_W-1:0] i_vdata,
  output logic               o_vram_we_b,
  output logic               o_vram_oe_b
);

  slot_t               slot_q, slot_d;
  logic                rd_pend_q, rd_pend_d;
  logic [VADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic                fill_busy_q, fill_busy_d;
  logic [VADDR_W-1:0]  fill_addr_q, fill_addr_d;
  logic [15:0]         fill_rem_q, fill_rem_d;
  logic [VDATA_W-1:0]  fill_val_q, fill_val_d;
  logic [VDATA_W-1:0]  rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic                drive_s;
  logic                reload_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [WR_ENTRY_W-1:0] fifo_head_s;
  logic                fill_avail_s;
  logic                rd_accept_s;
  logic                fill_accept_s;

  gfx_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WR_ENTRY_W)
  ) u_wr_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (cpu.i_wr_req),
    .pop_i   (pop_s),
    .wdata_i ({cpu.i_wr_addr, cpu.i_wr_data}),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .head_o  (fifo_head_s)
  );

  // The only path from i_free_vbus_b to the pins: one gate on the slot state.
  assign drive_s  = (slot_q.op != OP_NONE) && !i_free_vbus_b;
  // An empty slot refills at once; a full one only after its access lands.
  assign reload_s = (slot_q.op == OP_NONE) || drive_s;

  // Fill bytes only flow while no CPU write is queued.
  assign fill_avail_s  = fill_busy_q && (fill_rem_q != 16'd0) && fifo_empty_s;
  assign rd_accept_s   = cpu.i_rd_req && !rd_pend_q && (slot_q.op != OP_READ);
  assign fill_accept_s = cpu.i_fill_start && !fill_busy_q && (cpu.i_fill_len != 16'd0);

  // Next-state: read capture, request latching, fill bookkeeping, slot arbitration.
  always_comb begin
    slot_d      = slot_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    fill_busy_d = fill_busy_q;
    fill_addr_d = fill_addr_q;
    fill_rem_d  = fill_rem_q;
    fill_val_d  = fill_val_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    pop_s       = 1'b0;

    if (drive_s && (slot_q.op == OP_READ)) begin
      rd_data_d  = i_vdata;
      rd_valid_d = 1'b1;
    end else begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
    end

    // Last fill byte has been issued once the remaining count is zero.
    if (drive_s && (slot_q.op == OP_FILL) && (fill_rem_q == 16'd0)) begin
      fill_busy_d = 1'b0;
    end else if (fill_accept_s) begin
      fill_busy_d = 1'b1;
      fill_addr_d = cpu.i_fill_addr;
      fill_rem_d  = cpu.i_fill_len;
      fill_val_d  = cpu.i_fill_value;
    end else begin
      fill_busy_d = fill_busy_q;
    end

    if (rd_accept_s) begin
      rd_pend_d = 1'b1;
      rd_addr_d = cpu.i_rd_addr;
    end else begin
      rd_addr_d = rd_addr_q;
    end

    if (reload_s) begin
      if (rd_pend_q) begin
        slot_d.op   = OP_READ;
        slot_d.addr = rd_addr_q;
        slot_d.data = 8'h00;
        rd_pend_d   = 1'b0;
      end else if (!fifo_empty_s) begin
        slot_d.op   = OP_WRITE;
        slot_d.addr = fifo_head_s[WR_ENTRY_W-1:VDATA_W];
        slot_d.data = fifo_head_s[VDATA_W-1:0];
        pop_s       = 1'b1;
      end else if (fill_avail_s) begin
        slot_d.op   = OP_FILL;
        slot_d.addr = fill_addr_q;
        slot_d.data = fill_val_q;
        fill_addr_d = fill_addr_q + 16'd1;
        fill_rem_d  = fill_rem_q - 16'd1;
      end else begin
        slot_d = SLOT_IDLE;
      end
    end else begin
      slot_d = slot_q;
    end
  end

  // Scheduler state; slot_q.op is the FSM state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q      <= SLOT_IDLE;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= 16'h0000;
      fill_busy_q <= 1'b0;
      fill_addr_q <= 16'h0000;
      fill_rem_q  <= 16'h0000;
      fill_val_q  <= 8'h00;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      fill_busy_q <= fill_busy_d;
      fill_addr_q <= fill_addr_d;
      fill_rem_q  <= fill_rem_d;
      fill_val_q  <= fill_val_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign o_vaddr     = drive_s ? slot_q.addr : {VADDR_W{1'bz}};
  assign o_vdata     = (drive_s && op_writes(slot_q.op)) ? slot_q.data : {VDATA_W{1'bz}};
  assign o_vdata_oe  = drive_s && op_writes(slot_q.op);
  assign o_vram_we_b = !(drive_s && op_writes(slot_q.op));
  assign o_vram_oe_b = !(drive_s && (slot_q.op == OP_READ));

  assign cpu.o_wr_full   = fifo_full_s;
  assign cpu.o_fill_busy = fill_busy_q;
  assign cpu.o_rd_data   = rd_data_q;
  assign cpu.o_rd_valid  = rd_valid_q;

endmodule
